bcd_calculator: RTL and testbench

- Arithmetic stage directly downstream of the keypad/Numerator entry path.
- Consumes the two 4-digit BCD operands A1..A4 and B1..B4 and computes A+B, |A−B| with sign, or A×B.
- Presents an 8-digit BCD result and drives the end-of-calculation level that feeds StateMachine's end_obl input, replacing the current constant tie-off.

---
 rtl/bcd_calculator.sv | 174 +++++++++++++++++
 tb/tb_bcd_calculator.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bcd_calculator.sv
// bcd_calculator: 4-digit BCD add, signed subtract and shift-and-add multiply with an 8-digit result.
module bcd_calculator #(
   parameter bit MUL_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] op,
   input  logic [3:0] A1,
   input  logic [3:0] A2,
   input  logic [3:0] A3,
   input  logic [3:0] A4,
   input  logic [3:0] B1,
   input  logic [3:0] B2,
   input  logic [3:0] B3,
   input  logic [3:0] B4,
   output logic [3:0] R1,
   output logic [3:0] R2,
   output logic [3:0] R3,
   output logic [3:0] R4,
   output logic [3:0] R5,
   output logic [3:0] R6,
   output logic [3:0] R7,
   output logic [3:0] R8,
   output logic       neg,
   output logic       err,
   output logic       busy,
   output logic       done,
   output logic       end_obl
);
   typedef enum logic [2:0] {IDLE, ADDSUB, MUL_SHIFT, MUL_ADD, DONE} state_t;
   state_t      state_q, state_d;
   logic [15:0] a_q, a_d, b_q, b_d;
   logic [1:0]  op_q, op_d, idx_q, idx_d;
   logic [31:0] acc_q, acc_d, r_q, r_d;
   logic [3:0]  rep_q, rep_d;
   logic        neg_q, neg_d, err_q, err_d;
   logic [15:0] a_in, b_in;
   logic [31:0] sum_s, sub_s, mac_s;
   logic [3:0]  bdig;
   logic        ge, bad;

   function automatic logic [31:0] bcd_add(input logic [31:0] x, input logic [31:0] y, input logic ci);
      logic [4:0]  s;
      logic        c;
      logic [31:0] r;
      c = ci;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         s = {1'b0, x[4*i +: 4]} + {1'b0, y[4*i +: 4]} + {4'b0, c};
         c = s > 5'd9;
         r[4*i +: 4] = c ? s[3:0] + 4'd6 : s[3:0];
      end
      return r;
   endfunction

   function automatic logic [15:0] nines(input logic [15:0] x);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'd9 - x[4*i +: 4];
      return r;
   endfunction

   function automatic logic any_bad(input logic [31:0] x);
      logic b;
      b = 1'b0;
      for (int i = 0; i < 8; i++) b = b | (x[4*i +: 4] > 4'd9);
      return b;
   endfunction

   assign a_in  = {A1, A2, A3, A4};
   assign b_in  = {B1, B2, B3, B4};
   assign bad   = any_bad({a_in, b_in}) | (op == 2'b11) | (op == 2'b10 && !MUL_EN);
   assign ge    = a_q >= b_q;
   assign sum_s = bcd_add({16'h0, a_q}, {16'h0, b_q}, 1'b0);
   // Nines-complement plus one; the carry out of the 4th digit is discarded by the mask.
   assign sub_s = bcd_add({16'h0, ge ? a_q : b_q}, {16'h0, nines(ge ? b_q : a_q)}, 1'b1) & 32'h0000_FFFF;
   assign mac_s = bcd_add(acc_q, {16'h0, a_q}, 1'b0);
   assign bdig  = b_q[{~idx_q, 2'b00} +: 4];

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      rep_d   = rep_q;
      r_d     = r_q;
      neg_d   = neg_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (start) begin
            a_d   = a_in;
            b_d   = b_in;
            op_d  = op;
            acc_d = '0;
            idx_d = '0;
            rep_d = '0;
            if (bad) begin
               state_d = DONE;
               r_d     = '0;
               neg_d   = 1'b0;
               err_d   = 1'b1;
            end else state_d = op[1] ? MUL_SHIFT : ADDSUB;
         end
         ADDSUB: begin
            r_d     = op_q[0] ? sub_s : sum_s;
            neg_d   = op_q[0] & ~ge;
            err_d   = 1'b0;
            state_d = DONE;
         end
         MUL_SHIFT: begin
            acc_d = {acc_q[27:0], 4'h0};
            rep_d = bdig;
            if (bdig != 4'd0) state_d = MUL_ADD;
            else if (idx_q == 2'd3) begin
               r_d     = {acc_q[27:0], 4'h0};
               neg_d   = 1'b0;
               err_d   = 1'b0;
               state_d = DONE;
            end else idx_d = idx_q + 2'd1;
         end
         MUL_ADD: begin
            acc_d = mac_s;
            rep_d = rep_q - 4'd1;
            if (rep_q == 4'd1) begin
               if (idx_q == 2'd3) begin
                  r_d     = mac_s;
                  neg_d   = 1'b0;
                  err_d   = 1'b0;
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = MUL_SHIFT;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         rep_q   <= '0;
         r_q     <= '0;
         neg_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
         r_q     <= r_d;
         neg_q   <= neg_d;
         err_q   <= err_d;
      end
   end

   assign {R1, R2, R3, R4, R5, R6, R7, R8} = r_q;
   assign neg     = neg_q;
   assign err     = err_q;
   assign busy    = (state_q == ADDSUB) | (state_q == MUL_SHIFT) | (state_q == MUL_ADD);
   assign done    = state_q == DONE;
   assign end_obl = ~busy;
endmodule

// File: tb/tb_bcd_calculator.sv
// tb_bcd_calculator: directed vectors for bcd_calculator, with a second MUL_EN=0 instance for the multiply-disabled path.
module tb_bcd_calculator;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [15:0] a_in = '0, b_in = '0;
   logic [31:0] r_out, r0_out;
   logic        neg, err, busy, done, end_obl;
   logic        neg0, err0, busy0, done0, end_obl0;
   int          errors = 0, checks = 0;
   int          lat, bz, ndone, first;

   always #5 clk = ~clk;

   bcd_calculator #(.MUL_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .A1(a_in[15:12]), .A2(a_in[11:8]), .A3(a_in[7:4]), .A4(a_in[3:0]),
      .B1(b_in[15:12]), .B2(b_in[11:8]), .B3(b_in[7:4]), .B4(b_in[3:0]),
      .R1(r_out[31:28]), .R2(r_out[27:24]), .R3(r_out[23:20]), .R4(r_out[19:16]),
      .R5(r_out[15:12]), .R6(r_out[11:8]), .R7(r_out[7:4]), .R8(r_out[3:0]),
      .neg(neg), .err(err), .busy(busy), .done(done), .end_obl(end_obl)
   );

   bcd_calculator #(.MUL_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .A1(a_in[15:12]), .A2(a_in[11:8]), .A3(a_in[7:4]), .A4(a_in[3:0]),
      .B1(b_in[15:12]), .B2(b_in[11:8]), .B3(b_in[7:4]), .B4(b_in[3:0]),
      .R1(r0_out[31:28]), .R2(r0_out[27:24]), .R3(r0_out[23:20]), .R4(r0_out[19:16]),
      .R5(r0_out[15:12]), .R6(r0_out[11:8]), .R7(r0_out[7:4]), .R8(r0_out[3:0]),
      .neg(neg0), .err(err0), .busy(busy0), .done(done0), .end_obl(end_obl0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One start pulse, operands scrambled right after capture; returns edges-to-done and busy cycles.
   task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o,
                      output int l, output int nb);
      @(posedge clk); #1;
      a_in = a; b_in = b; op = o; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a_in = 16'h9999; b_in = 16'h9999; op = 2'b00;
      l = 0; nb = 0;
      while (!done && l < 60) begin
         nb += int'(busy);
         @(posedge clk); #1;
         l++;
      end
      chk("busy_in_done", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      chk("done_pulse_width", {31'b0, done}, 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_R", r_out, 32'h0);
      chk("rst_flags", {27'b0, neg, err, busy, done, end_obl}, 32'b00001);
      rst = 1'b1;

      run(16'h9999, 16'h0001, 2'b00, lat, bz);
      chk("add_lat", lat, 1);
      chk("add_busy", bz, 1);
      chk("add_R", r_out, 32'h0001_0000);
      chk("add_ne", {30'b0, neg, err}, 32'd0);

      run(16'h0123, 16'h0456, 2'b01, lat, bz);
      chk("subn_lat", lat, 1);
      chk("subn_R", r_out, 32'h0000_0333);
      chk("subn_neg", {31'b0, neg}, 32'd1);
      run(16'h0456, 16'h0456, 2'b01, lat, bz);
      chk("subz_R", r_out, 32'h0);
      chk("subz_neg", {31'b0, neg}, 32'd0);
      run(16'h5000, 16'h0001, 2'b01, lat, bz);
      chk("subp_R", r_out, 32'h0000_4999);

      run(16'h1234, 16'h0000, 2'b10, lat, bz);
      chk("mul0_lat", lat, 4);
      chk("mul0_R", r_out, 32'h0);
      run(16'h9999, 16'h9999, 2'b10, lat, bz);
      chk("mulmax_lat", lat, 40);
      chk("mulmax_busy", bz, 40);
      chk("mulmax_R", r_out, 32'h9998_0001);
      chk("mulmax_ne", {30'b0, neg, err}, 32'd0);

      run(16'h0A23, 16'h0001, 2'b00, lat, bz);
      chk("baddig_lat", lat, 0);
      chk("baddig_err", {31'b0, err}, 32'd1);
      chk("baddig_R", r_out, 32'h0);
      run(16'h0001, 16'h0001, 2'b00, lat, bz);
      chk("clear_err", {31'b0, err}, 32'd0);
      chk("clear_R", r_out, 32'h2);
      run(16'h0001, 16'h0001, 2'b11, lat, bz);
      chk("op11_lat", lat, 0);
      chk("op11_err", {31'b0, err}, 32'd1);
      chk("op11_R", r_out, 32'h0);
      run(16'h0001, 16'h0001, 2'b00, lat, bz);
      chk("noMUL_add_R", r0_out, 32'h2);
      chk("noMUL_add_err", {31'b0, err0}, 32'd0);
      run(16'h0012, 16'h0003, 2'b10, lat, bz);
      chk("mul12x3_R", r_out, 32'h36);
      chk("noMUL_err", {31'b0, err0}, 32'd1);
      chk("noMUL_R", r0_out, 32'h0);

      // Repeated starts with other operands while busy must not disturb the multiply.
      @(posedge clk); #1;
      a_in = 16'h0002; b_in = 16'h0305; op = 2'b10; start = 1'b1;
      @(posedge clk); #1;
      ndone = 0; first = -1;
      for (int i = 1; i <= 30; i++) begin
         a_in = 16'h0777; b_in = 16'h0011; op = 2'b00;
         start = (ndone == 0) && i[0];
         @(posedge clk); #1;
         if (done) begin
            ndone++;
            if (first < 0) first = i;
            start = 1'b0;
         end
      end
      chk("busy_start_ndone", ndone, 1);
      chk("busy_start_lat", first, 12);
      chk("busy_start_R", r_out, 32'h0000_0610);
      run(16'h0002, 16'h0003, 2'b00, lat, bz);
      chk("after_busy_lat", lat, 1);
      chk("after_busy_R", r_out, 32'h5);

      @(posedge clk); #1;
      a_in = 16'h1234; b_in = 16'h9999; op = 2'b10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst_R", r_out, 32'h0);
      chk("midrst_flags", {27'b0, neg, err, busy, done, end_obl}, 32'b00001);
      @(posedge clk); #1;
      rst = 1'b1;
      run(16'h0001, 16'h0002, 2'b00, lat, bz);
      chk("postrst_lat", lat, 1);
      chk("postrst_R", r_out, 32'h3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
